// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/MEM latches.
// Merges memory wait states, load-use interlock and branch squash.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       ID_src_a,
  input  logic [4:0]       ID_src_b,
  input  logic [4:0]       EX_wr_id,
  input  logic             EX_is_load,
  input  logic             EX_taken,
  input  logic             MEM_req,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_MWAIT = 1'b1;

  localparam bit         WAIT_EN = (MEM_WAIT > 0);
  // MWAIT only covers the cycles after the request cycle
  localparam bit         MULTI   = (MEM_WAIT > 1);
  localparam logic [3:0] WLOAD   = 4'(MEM_WAIT - 1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_stall;
  logic load_use;

  assign mem_stall = (state_q == S_IDLE && MEM_req && WAIT_EN)
                   || (state_q == S_MWAIT);

  assign load_use = EX_is_load
                 && (EX_wr_id != 5'd0)
                 && ((EX_wr_id == ID_src_a)
                  || (EX_wr_id == ID_src_b));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (MEM_req && MULTI) begin
          state_d = S_MWAIT;
          wcnt_d  = WLOAD;
        end
      end
      S_MWAIT: begin
        if (wcnt_q <= 4'd1) begin
          state_d = S_IDLE;
          wcnt_d  = 4'd0;
        end else begin
          wcnt_d  = wcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    if (mem_stall) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      stall_EX  = 1'b1;
      stall_MEM = 1'b1;
    end else if (EX_taken) begin
      flush_ID  = 1'b1;
      flush_EX  = 1'b1;
    end else if (load_use) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      flush_EX  = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_IF && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_busy  = (state_q == S_MWAIT);
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues
// hand-computed per-cycle expectations, monitor checks them.
module tb_pipe_hazard_ctrl;

  localparam int CW = 12;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [4:0]    ID_src_a = '0;
  logic [4:0]    ID_src_b = '0;
  logic [4:0]    EX_wr_id = '0;
  logic          EX_is_load = 1'b0;
  logic          EX_taken = 1'b0;
  logic          MEM_req = 1'b0;
  logic          stall_IF, stall_ID, stall_EX, stall_MEM;
  logic          flush_ID, flush_EX, mem_busy;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MEM_WAIT(2), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .ID_src_a(ID_src_a), .ID_src_b(ID_src_b),
    .EX_wr_id(EX_wr_id), .EX_is_load(EX_is_load),
    .EX_taken(EX_taken), .MEM_req(MEM_req),
    .stall_IF(stall_IF), .stall_ID(stall_ID),
    .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .flush_ID(flush_ID), .flush_EX(flush_EX),
    .mem_busy(mem_busy), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string         nm;
    logic [6:0]    o;
    logic [CW-1:0] c;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] exp_cnt = '0;

  // {sIF,sID,sEX,sMEM,fID,fEX,busy}
  localparam logic [6:0] O_ZERO = 7'b0000_00_0;
  localparam logic [6:0] O_MREQ = 7'b1111_00_0;
  localparam logic [6:0] O_MWT  = 7'b1111_00_1;
  localparam logic [6:0] O_LU   = 7'b1100_01_0;
  localparam logic [6:0] O_BR   = 7'b0000_11_0;

  always @(negedge CLK) begin
    exp_t       e;
    logic [6:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {stall_IF, stall_ID, stall_EX, stall_MEM,
             flush_ID, flush_EX, mem_busy};
      tests++;
      if (act !== e.o) begin
        fails++;
        $display("FAIL %s outs: got %b want %b", e.nm, act, e.o);
      end
      tests++;
      if (stall_cnt !== e.c) begin
        fails++;
        $display("FAIL %s cnt: got %0d want %0d",
                 e.nm, stall_cnt, e.c);
      end
    end
  end

  task automatic cyc(input string nm, input logic rst,
                     input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] wr, input logic ld,
                     input logic tk, input logic mreq,
                     input logic [6:0] o);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; ID_src_a = a; ID_src_b = b;
    EX_wr_id = wr; EX_is_load = ld;
    EX_taken = tk; MEM_req = mreq;
    e.nm = nm; e.o = o; e.c = exp_cnt;
    sb.push_back(e);
    if (rst) exp_cnt = '0;
    else if (o[6] && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    cyc("rst_state", 0, 0, 0, 0, 0, 0, 0, O_ZERO);
    cyc("mem_c5",    0, 0, 0, 0, 0, 0, 1, O_MREQ);
    cyc("mem_c6",    0, 0, 0, 0, 0, 0, 0, O_MWT);
    cyc("mem_c7",    0, 0, 0, 0, 0, 0, 0, O_ZERO);
    cyc("lu_b",      0, 0, 3, 3, 1, 0, 0, O_LU);
    cyc("lu_clear",  0, 0, 0, 0, 0, 0, 0, O_ZERO);
    cyc("lu_a",      0, 7, 1, 7, 1, 0, 0, O_LU);
    cyc("br_over_lu",0, 0, 3, 3, 1, 1, 0, O_BR);
    cyc("lu_r0",     0, 0, 0, 0, 1, 0, 0, O_ZERO);
    cyc("lu_wr0",    0, 0, 5, 0, 1, 0, 0, O_ZERO);
    cyc("no_load",   0, 3, 0, 3, 0, 0, 0, O_ZERO);
    cyc("lu_miss",   0, 4, 6, 3, 1, 0, 0, O_ZERO);
    cyc("bw_req",    0, 0, 0, 0, 0, 0, 1, O_MREQ);
    cyc("br_in_wait",0, 0, 0, 0, 0, 1, 0, O_MWT);
    cyc("br_after",  0, 0, 0, 0, 0, 1, 0, O_BR);
    cyc("br_clear",  0, 0, 0, 0, 0, 0, 0, O_ZERO);
    cyc("mlu_req",   0, 9, 0, 9, 1, 0, 1, O_MREQ);
    cyc("mlu_wait",  0, 9, 0, 9, 1, 0, 0, O_MWT);
    cyc("mlu_lu",    0, 9, 0, 9, 1, 0, 0, O_LU);
    cyc("mlu_clear", 0, 0, 0, 0, 0, 0, 0, O_ZERO);
    cyc("rw_req",    0, 0, 0, 0, 0, 0, 1, O_MREQ);
    cyc("rw_rst",    1, 0, 0, 0, 0, 0, 1, O_MWT);
    cyc("rw_idle",   0, 0, 0, 0, 0, 0, 0, O_ZERO);
    for (int i = 0; i < 4100; i++) begin
      cyc("sat_hold", 0, 0, 2, 2, 1, 0, 0, O_LU);
    end
    cyc("sat_end",   0, 0, 0, 0, 0, 0, 0, O_ZERO);
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    #1;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d left want 0", sb.size());
    end
    tests++;
    if (stall_cnt !== {CW{1'b1}}) begin
      fails++;
      $display("FAIL sat_final: got %0h want %0h",
               stall_cnt, {CW{1'b1}});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
